video_timing_pattern_gen: RTL and testbench



---
 rtl/video_timing_pattern_gen_if.sv | 20 ++
 rtl/video_timing_pattern_gen.sv | 148 ++++++++++++++
 tb/tb_video_timing_pattern_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_pattern_gen_if.sv
// Pixel stream from the timing/pattern source to the TMDS encoders.
// Stream semantics: de qualifies red/green/blue as an active pixel on every clock;
// there is no ready, so the sink must accept every cycle. x/y/syncs/sof travel with de.
interface video_timing_pattern_gen_if #(
   parameter int CW  = 12,
   parameter int BPC = 8
);
   logic [CW-1:0]  x;
   logic [CW-1:0]  y;
   logic           de;
   logic           hsync;
   logic           vsync;
   logic           sof;
   logic [BPC-1:0] red;
   logic [BPC-1:0] green;
   logic [BPC-1:0] blue;

   modport master (output x, y, de, hsync, vsync, sof, red, green, blue);
   modport slave  (input  x, y, de, hsync, vsync, sof, red, green, blue);
endinterface

// File: rtl/video_timing_pattern_gen.sv
// Raster timing generator with four selectable test patterns; all outputs are
// registered one cycle after the hcnt/vcnt state they describe.
module video_timing_pattern_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b1,
   parameter logic VS_POL   = 1'b1,
   parameter int   CW       = 12,
   parameter int   BPC      = 8,
   parameter int   CHK_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [1:0]            mode,
   input  logic [3*BPC-1:0]      solid_rgb,
   video_timing_pattern_gen_if.master vid
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BAR_W   = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

   logic [CW-1:0]  hcnt, vcnt, bar_pos;
   logic [2:0]     bar_idx;
   logic [BPC-1:0] fcnt;
   logic [1:0]     mode_q;

   logic h_wrap, v_wrap, at_origin, active, hs_on, vs_on;
   logic [1:0]       eff_mode;
   logic [2:0]       bar_bits;
   logic [3*BPC-1:0] pix_rgb;

   logic [CW-1:0]    x_r, y_r;
   logic             de_r, hsync_r, vsync_r, sof_r;
   logic [3*BPC-1:0] rgb_r;

   assign h_wrap    = (hcnt == H_LAST);
   assign v_wrap    = (vcnt == V_LAST);
   assign at_origin = (hcnt == '0) && (vcnt == '0);
   assign active    = (hcnt < H_ACT) && (vcnt < V_ACT);
   assign hs_on     = (hcnt >= HS_START) && (hcnt < HS_END);
   assign vs_on     = (vcnt >= VS_START) && (vcnt < VS_END);
   // The frame's first pixel already uses the incoming mode, as mode_q loads on that same edge.
   assign eff_mode  = at_origin ? mode : mode_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt    <= '0;
         vcnt    <= '0;
         fcnt    <= '0;
         mode_q  <= '0;
         bar_pos <= '0;
         bar_idx <= '0;
      end else if (en) begin
         hcnt <= h_wrap ? '0 : hcnt + CW'(1);
         if (h_wrap) vcnt <= v_wrap ? '0 : vcnt + CW'(1);
         if (h_wrap && v_wrap) fcnt <= fcnt + BPC'(1);
         if (at_origin) mode_q <= mode;
         // Bar index tracks hcnt/BAR_W incrementally, saturating at the last bar.
         if (h_wrap) begin
            bar_pos <= '0;
            bar_idx <= '0;
         end else if (bar_pos == BAR_LAST) begin
            bar_pos <= '0;
            if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_pos <= bar_pos + CW'(1);
         end
      end
   end

   always_comb begin
      bar_bits = 3'b000;
      case (bar_idx)
         3'd0: bar_bits = 3'b111;
         3'd1: bar_bits = 3'b110;
         3'd2: bar_bits = 3'b011;
         3'd3: bar_bits = 3'b010;
         3'd4: bar_bits = 3'b101;
         3'd5: bar_bits = 3'b100;
         3'd6: bar_bits = 3'b001;
         default: bar_bits = 3'b000;
      endcase
   end

   always_comb begin
      pix_rgb = '0;
      case (eff_mode)
         2'd0: pix_rgb = solid_rgb;
         2'd1: pix_rgb = {{BPC{bar_bits[2]}}, {BPC{bar_bits[1]}}, {BPC{bar_bits[0]}}};
         2'd2: pix_rgb = (hcnt[CHK_LOG2] ^ vcnt[CHK_LOG2]) ? '0 : '1;
         default: pix_rgb = {hcnt[BPC-1:0], vcnt[BPC-1:0], fcnt};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_r     <= '0;
         y_r     <= '0;
         de_r    <= 1'b0;
         hsync_r <= ~HS_POL;
         vsync_r <= ~VS_POL;
         sof_r   <= 1'b0;
         rgb_r   <= '0;
      end else if (en) begin
         x_r     <= hcnt;
         y_r     <= vcnt;
         de_r    <= active;
         hsync_r <= hs_on ? HS_POL : ~HS_POL;
         vsync_r <= vs_on ? VS_POL : ~VS_POL;
         sof_r   <= at_origin;
         rgb_r   <= active ? pix_rgb : '0;
      end else begin
         // Paused: position holds, everything else goes quiet.
         de_r    <= 1'b0;
         hsync_r <= ~HS_POL;
         vsync_r <= ~VS_POL;
         sof_r   <= 1'b0;
         rgb_r   <= '0;
      end
   end

   assign vid.x     = x_r;
   assign vid.y     = y_r;
   assign vid.de    = de_r;
   assign vid.hsync = hsync_r;
   assign vid.vsync = vsync_r;
   assign vid.sof   = sof_r;
   assign vid.red   = rgb_r[3*BPC-1:2*BPC];
   assign vid.green = rgb_r[2*BPC-1:BPC];
   assign vid.blue  = rgb_r[BPC-1:0];
endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Bench for video_timing_pattern_gen on a tiny 16x8 raster: directed scenarios
// plus random stimulus, every cycle compared against a linear-pixel-index model.
module tb_video_timing_pattern_gen;
   localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
   localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int CW = 12, BPC = 8, CHK = 1;

   logic        clk, rst, en;
   logic [1:0]  mode;
   logic [23:0] solid_rgb;

   video_timing_pattern_gen_if #(.CW(CW), .BPC(BPC)) vif ();

   video_timing_pattern_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW), .BPC(BPC), .CHK_LOG2(CHK)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb), .vid(vif.master)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   // reference model: raster position as a single pixel index within the frame
   int          m_pix = 0, m_frame = 0;
   logic [1:0]  m_mode = 2'd0;
   logic [11:0] ex = '0, ey = '0;
   logic        ede = 1'b0, ehs = 1'b0, evs = 1'b0, esof = 1'b0;
   logic [23:0] ergb = '0;
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   function automatic logic [23:0] colour(input logic [1:0] md, input int h, input int v,
                                          input logic [23:0] c, input int f);
      int idx;
      case (md)
         2'd0: return c;
         2'd1: begin
            idx = h / (H_ACTIVE / 8);
            if (idx > 7) idx = 7;
            return bars[idx];
         end
         2'd2: return ((((h >> CHK) ^ (v >> CHK)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
         default: return {8'(h % 256), 8'(v % 256), 8'(f % 256)};
      endcase
   endfunction

   task automatic model(input bit r, input bit e, input logic [1:0] md, input logic [23:0] c);
      int h, v;
      if (r) begin
         m_pix = 0; m_frame = 0; m_mode = 2'd0;
         ex = '0; ey = '0; ede = 0; ehs = 0; evs = 0; esof = 0; ergb = '0;
      end else if (e) begin
         h = m_pix % HT;
         v = m_pix / HT;
         if (m_pix == 0) m_mode = md;
         ex   = 12'(h);
         ey   = 12'(v);
         ede  = (h < H_ACTIVE) && (v < V_ACTIVE);
         ehs  = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
         evs  = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
         esof = (m_pix == 0);
         ergb = ede ? colour(m_mode, h, v, c, m_frame) : 24'h0;
         m_pix = (m_pix + 1) % (HT * VT);
         if (m_pix == 0) m_frame = (m_frame + 1) % 256;
      end else begin
         ede = 0; ehs = 0; evs = 0; esof = 0; ergb = '0;
      end
   endtask

   // driver: apply inputs, clock once, compare the whole output word
   task automatic step(input bit r, input bit e, input logic [1:0] md, input logic [23:0] c);
      rst = r; en = e; mode = md; solid_rgb = c;
      @(posedge clk);
      model(r, e, md, c);
      #1;
      check("pixel", {vif.x, vif.y, vif.de, vif.hsync, vif.vsync, vif.sof,
                      vif.red, vif.green, vif.blue},
            {ex, ey, ede, ehs, evs, esof, ergb});
      @(negedge clk);
   endtask

   task automatic run_to_sof(input logic [1:0] md, input logic [23:0] c);
      int k = 0;
      do begin
         step(0, 1, md, c);
         k++;
      end while (!vif.sof && k < 300);
      check("sof_found", 64'(vif.sof), 64'd1);
   endtask

   function automatic logic [23:0] rgb_now();
      return {vif.red, vif.green, vif.blue};
   endfunction

   initial begin
      int last, vs_cnt, de_cnt, de_bad;
      logic [23:0] c;
      logic [1:0]  md;
      bit          r, e;
      rst = 1'b1; en = 1'b0; mode = 2'd0; solid_rgb = 24'h0;

      repeat (3) step(1, 1, 0, 24'h123456);
      check("rst_hsync", 64'(vif.hsync), 64'd0);
      check("rst_rgb", 64'(rgb_now()), 64'd0);

      step(0, 1, 0, 24'h123456);
      check("first_sof", 64'({vif.x, vif.y, vif.de, vif.sof}), 64'({12'd0, 12'd0, 1'b1, 1'b1}));
      check("first_rgb", 64'(rgb_now()), 64'h123456);

      last = 0; vs_cnt = 0; de_cnt = 0; de_bad = 0;
      for (int i = 1; i <= 3 * HT * VT; i++) begin
         step(0, 1, 0, 24'h123456);
         if (vif.sof) begin
            check("sof_period", 64'(i - last), 64'(HT * VT));
            last = i;
         end
         if (vif.vsync) vs_cnt++;
         if (vif.de) de_cnt++;
         if (vif.de && vif.y >= 12'(V_ACTIVE)) de_bad++;
      end
      check("vsync_cycles", 64'(vs_cnt), 64'(3 * 2 * HT));
      check("de_cycles", 64'(de_cnt), 64'(3 * H_ACTIVE * V_ACTIVE));
      check("de_in_vblank", 64'(de_bad), 64'd0);

      // colour bars on line 0
      step(0, 1, 1, 24'h123456);
      run_to_sof(1, 24'h123456);
      check("bar0", 64'(rgb_now()), 64'hFFFFFF);
      for (int i = 1; i < 8; i++) begin
         step(0, 1, 1, 24'h123456);
         check($sformatf("bar%0d", i), 64'(rgb_now()), 64'(bars[i]));
      end

      // checkerboard, then a mid-frame switch that must wait for the next frame
      run_to_sof(2, 24'h123456);
      check("chk_0_0", 64'(rgb_now()), 64'hFFFFFF);
      repeat (2) step(0, 1, 2, 24'h123456);
      check("chk_2_0", 64'(rgb_now()), 64'h000000);
      repeat (HT - 2) step(0, 1, 2, 24'h123456);
      repeat (HT) step(0, 1, 0, 24'h123456);
      check("chk_0_2", 64'(rgb_now()), 64'h000000);
      repeat (2) step(0, 1, 0, 24'h123456);
      check("chk_2_2", 64'(rgb_now()), 64'hFFFFFF);
      run_to_sof(0, 24'h123456);
      check("solid_after_switch", 64'(rgb_now()), 64'h123456);

      // pause at (3,1)
      repeat (HT + 3) step(0, 1, 0, 24'h123456);
      check("pause_pos", 64'({vif.x, vif.y}), 64'({12'd3, 12'd1}));
      repeat (5) begin
         step(0, 0, 0, 24'h123456);
         check("pause_quiet", 64'({vif.de, vif.sof, vif.hsync, vif.vsync, rgb_now()}), 64'd0);
      end
      step(0, 1, 0, 24'h123456);
      check("resume_pos", 64'({vif.x, vif.y}), 64'({12'd4, 12'd1}));

      // ramp over three frames from a fresh reset, then reset mid-frame
      step(1, 1, 3, 24'h0);
      step(0, 1, 3, 24'h0);
      repeat (2 * HT + 5) step(0, 1, 3, 24'h0);
      check("ramp_f0", 64'(rgb_now()), 64'h050200);
      repeat (HT * VT) step(0, 1, 3, 24'h0);
      check("ramp_f1", 64'(rgb_now()), 64'h050201);
      repeat (HT * VT) step(0, 1, 3, 24'h0);
      check("ramp_f2", 64'(rgb_now()), 64'h050202);
      repeat (HT + 1) step(0, 1, 3, 24'h0);
      check("pre_rst_pos", 64'({vif.x, vif.y}), 64'({12'd6, 12'd3}));
      step(1, 1, 3, 24'h0);
      check("mid_rst", 64'({vif.x, vif.y, vif.de, vif.sof, vif.hsync, vif.vsync, rgb_now()}), 64'd0);
      step(0, 1, 3, 24'h0);
      check("restart", 64'({vif.x, vif.y, vif.de, vif.sof, vif.blue}),
            64'({12'd0, 12'd0, 1'b1, 1'b1, 8'd0}));

      // frame counter wrap through 2^BPC frames
      repeat (258 * HT * VT) step(0, 1, 3, 24'h0);

      // random stimulus
      md = 2'd0;
      c  = 24'h0;
      for (int i = 0; i < 4000; i++) begin
         r = ($urandom_range(0, 399) == 0);
         e = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 63) == 0) md = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) c = 24'($urandom);
         step(r, e, md, c);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
